dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_timeout_cnt.sv | 32 +++
 rtl/dmem_ctrl.sv | 144 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding,
// default error word and timeout counter width.
package dmem_pkg;

  // Width of the BUSY-cycle counter; TIMEOUT must fit in it (1..255).
  localparam int CNT_W = 8;

  // Value handed back to the datapath when a load times out.
  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Clear/enable cycle counter that flags its terminal count (TIMEOUT-1),
// used to bound how long the controller waits for a memory ack.
module dmem_timeout_cnt
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  // Count BUSY cycles; clear has priority so every wait starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == TC_VAL);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns datapath load/store requests into a
// req/ack handshake on an external memory, stalling the datapath while
// the access is outstanding and aborting after TIMEOUT cycles.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] ERR_WORD = ERR_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        AlignErr,
  output logic        TimeoutErr
);

  state_t      state_reg;
  state_t      state_next;

  logic        request;
  logic        aligned;
  logic        issue;
  logic        misalign;
  logic        in_busy;
  logic        cnt_tc;

  logic        we_reg;
  logic        rd_reg;
  logic [29:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        align_err_reg;
  logic        timeout_err_reg;

  assign request  = MemRead | MemWrite;
  assign aligned  = (ALUResult[1:0] == 2'b00);
  assign issue    = (state_reg == IDLE) && request && aligned;
  assign misalign = (state_reg == IDLE) && request && !aligned;
  assign in_busy  = (state_reg == BUSY);

  // Counter is held at zero outside BUSY so each wait starts fresh.
  dmem_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (!in_busy),
    .enable(in_busy),
    .tc    (cnt_tc)
  );

  // State register; reset drops straight to IDLE, which also kills mem_req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake/stall outputs.
  always_comb begin
    state_next = state_reg;
    Stall      = 1'b0;
    mem_req    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (issue) begin
          Stall      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        Stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack || cnt_tc) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture, load data return and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg          <= 1'b0;
      rd_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      rdata_reg       <= '0;
      align_err_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (issue) begin
        addr_reg  <= ALUResult[31:2];
        wdata_reg <= WriteData;
        we_reg    <= MemWrite;
        // A simultaneous read+write request is carried out as a store only.
        rd_reg    <= MemRead & ~MemWrite;
      end
      if (misalign) begin
        align_err_reg <= 1'b1;
      end
      if (in_busy) begin
        // Ack beats timeout when both land in the same cycle.
        if (mem_ack) begin
          if (rd_reg) begin
            rdata_reg <= mem_rdata;
          end
        end else if (cnt_tc) begin
          timeout_err_reg <= 1'b1;
          if (rd_reg) begin
            rdata_reg <= ERR_WORD;
          end
        end
      end
    end
  end

  assign mem_we     = we_reg & mem_req;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign ReadData   = rdata_reg;
  assign AlignErr   = align_err_reg;
  assign TimeoutErr = timeout_err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: stimulus pushes hand-computed expectations
// into a scoreboard; a negedge monitor pops one entry per completed access.
module tb_dmem_ctrl;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        AlignErr;
  logic        TimeoutErr;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        terr;
    int          stall;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb_q[$];

  dmem_ctrl #(
    .TIMEOUT (15),
    .ERR_WORD(32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .AlignErr  (AlignErr),
    .TimeoutErr(TimeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: tracks stall cycles and the issued request, compares at DONE.
  int          mon_stall = 0;
  logic        mon_seen  = 1'b0;
  logic        mon_prev  = 1'b0;
  logic        mon_we;
  logic [29:0] mon_addr;
  logic [31:0] mon_wdata;

  always @(negedge clk) begin
    if (reset) begin
      mon_stall = 0;
      mon_seen  = 1'b0;
      mon_prev  = 1'b0;
    end else begin
      if (Stall) mon_stall++;
      if (mem_req && !mon_seen) begin
        mon_seen  = 1'b1;
        mon_we    = mem_we;
        mon_addr  = mem_addr;
        mon_wdata = mem_wdata;
      end
      if (mon_prev && !mem_req) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected: completion with empty scoreboard, ReadData=%h", ReadData);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("txn %s: addr=%h we=%b wdata=%h rdata=%h terr=%b stall=%0d",
                   e.tag, mon_addr, mon_we, mon_wdata, ReadData, TimeoutErr, mon_stall);
          chk({e.tag, ".addr"},  {2'b00, mon_addr}, {2'b00, e.addr});
          chk({e.tag, ".we"},    {31'd0, mon_we},   {31'd0, e.we});
          chk({e.tag, ".wdata"}, mon_wdata,         e.wdata);
          chk({e.tag, ".rdata"}, ReadData,          e.rdata);
          chk({e.tag, ".terr"},  {31'd0, TimeoutErr}, {31'd0, e.terr});
          chk({e.tag, ".stall"}, 32'(mon_stall),    32'(e.stall));
          chk({e.tag, ".req_done"}, {31'd0, mem_req}, 32'd0);
        end
        mon_stall = 0;
        mon_seen  = 1'b0;
      end
      mon_prev = mem_req;
    end
  end

  // One access: called at posedge+1 with the DUT idle; ack_at counts BUSY
  // cycles from 1 (0 = never ack).
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic [31:0] rdata,
                        input logic [31:0] e_rdata, input logic e_terr,
                        input int e_stall, input logic [29:0] e_addr);
    exp_t e;
    e.tag = tag; e.rdata = e_rdata; e.terr = e_terr; e.stall = e_stall;
    e.we = wr; e.addr = e_addr; e.wdata = wdata;
    sb_q.push_back(e);
    MemRead = rd; MemWrite = wr; ALUResult = addr; WriteData = wdata;
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      if (!mem_req) break;
      if (c == ack_at) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    chk({tag, ".bounded"}, {31'd0, mem_req}, 32'd0);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ALUResult = '0; WriteData = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst.ReadData",   ReadData, 32'd0);
    chk("rst.mem_req",    {31'd0, mem_req}, 32'd0);
    chk("rst.mem_we",     {31'd0, mem_we}, 32'd0);
    chk("rst.Stall",      {31'd0, Stall}, 32'd0);
    chk("rst.mem_addr",   {2'b00, mem_addr}, 32'd0);
    chk("rst.mem_wdata",  mem_wdata, 32'd0);
    chk("rst.AlignErr",   {31'd0, AlignErr}, 32'd0);
    chk("rst.TimeoutErr", {31'd0, TimeoutErr}, 32'd0);
    @(posedge clk); #1;

    access("load_100",  1, 0, 32'h100, 32'h0,        3,  32'h12345678, 32'h12345678, 0, 4,  30'h40);
    access("store_204", 0, 1, 32'h204, 32'hCAFEF00D, 1,  32'hFFFFFFFF, 32'h12345678, 0, 2,  30'h81);

    // Misaligned load: no transaction, no stall, sticky AlignErr next edge.
    MemRead = 1'b1; ALUResult = 32'h102;
    #1;
    chk("misal.Stall",    {31'd0, Stall}, 32'd0);
    chk("misal.mem_req",  {31'd0, mem_req}, 32'd0);
    chk("misal.AlignErr_pre", {31'd0, AlignErr}, 32'd0);
    @(posedge clk); #1;
    chk("misal.AlignErr", {31'd0, AlignErr}, 32'd1);
    chk("misal.mem_req2", {31'd0, mem_req}, 32'd0);
    MemRead = 1'b0;
    @(posedge clk); #1;
    chk("misal.sticky",   {31'd0, AlignErr}, 32'd1);

    access("ack_at_tc", 1, 0, 32'h8,   32'h13572468, 15, 32'hA5A50F0F, 32'hA5A50F0F, 0, 16, 30'h2);
    access("timeout",   1, 0, 32'h300, 32'h0,        0,  32'h0,        32'hDEADBEEF, 1, 16, 30'hC0);
    access("rd_and_wr", 1, 1, 32'h10,  32'h11112222, 2,  32'h99999999, 32'hDEADBEEF, 1, 3,  30'h4);

    // Ack while idle must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'h00000055;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("idle_ack.ReadData", ReadData, 32'hDEADBEEF);
    chk("idle_ack.mem_req",  {31'd0, mem_req}, 32'd0);

    // Reset during the second BUSY cycle, then a late ack.
    MemRead = 1'b1; ALUResult = 32'h40;
    @(posedge clk); #1;
    chk("rstbusy.req_c1", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    #1 reset = 1'b1;
    #1;
    chk("rstbusy.mem_req",    {31'd0, mem_req}, 32'd0);
    chk("rstbusy.ReadData",   ReadData, 32'd0);
    chk("rstbusy.TimeoutErr", {31'd0, TimeoutErr}, 32'd0);
    chk("rstbusy.AlignErr",   {31'd0, AlignErr}, 32'd0);
    MemRead = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h00000077;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack.ReadData", ReadData, 32'd0);
    chk("late_ack.mem_req",  {31'd0, mem_req}, 32'd0);
    chk("late_ack.Stall",    {31'd0, Stall}, 32'd0);

    access("load_4", 1, 0, 32'h4, 32'h0, 1, 32'h0BADF00D, 32'h0BADF00D, 0, 2, 30'h1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
